// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped branch history table with a branch target
//                buffer. Every entry holds a 2-bit saturating counter, a
//                valid bit and a target PC. Fetch reads the table
//                combinationally to choose the next PC. The EX stage writes
//                resolved branches back and updates the branch and
//                misprediction statistics.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   rising-edge clock
//    reset        in   asynchronous, active-high reset
//    IF_PC        in   PC being fetched
//    IF_predTaken out  prediction for IF_PC (1 = taken)
//    IF_predPC    out  next fetch PC (BTB target or IF_PC + 4)
//    EX_valid     in   EX holds a real instruction (not a bubble)
//    EX_PC        in   PC of the instruction in EX
//    EX_opcode    in   opcode of the instruction in EX
//    EX_taken     in   resolved branch outcome
//    EX_target    in   resolved branch target
//    EX_pred      in   prediction that travelled with this instruction
//    branchCount  out  resolved-branch count (saturating)
//    mispredCount out  misprediction count (saturating)
// ============================================================================
module branch_predictor #(
    parameter int         DBITS     = 32,
    parameter int         IDX_BITS  = 4,
    parameter logic [3:0] BRANCH_OP = 4'b0010,
    parameter int         STAT_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    // fetch-side lookup
    input  logic [DBITS-1:0]     IF_PC,
    output logic                 IF_predTaken,
    output logic [DBITS-1:0]     IF_predPC,
    // execute-side update
    input  logic                 EX_valid,
    input  logic [DBITS-1:0]     EX_PC,
    input  logic [3:0]           EX_opcode,
    input  logic                 EX_taken,
    input  logic [DBITS-1:0]     EX_target,
    input  logic                 EX_pred,
    // statistics
    output logic [STAT_BITS-1:0] branchCount,
    output logic [STAT_BITS-1:0] mispredCount
);

    localparam int c_ENTRIES = 1 << IDX_BITS;

    // Per-entry 2-bit saturating counter states.
    typedef enum logic [1:0] {
        SNT = 2'b00,   // strongly not-taken
        WNT = 2'b01,   // weakly not-taken (reset state)
        WT  = 2'b10,   // weakly taken
        ST  = 2'b11    // strongly taken
    } ctr_state_t;

    // ------------------------------------------------------------------------
    // Table storage and statistics
    // ------------------------------------------------------------------------
    ctr_state_t           r_ctr    [c_ENTRIES];
    logic                 r_valid  [c_ENTRIES];
    logic [DBITS-1:0]     r_target [c_ENTRIES];
    logic [STAT_BITS-1:0] r_branch_cnt;
    logic [STAT_BITS-1:0] r_mispred_cnt;

    // ------------------------------------------------------------------------
    // Index extraction. PCs are word aligned, so bits [1:0] carry no
    // information; there are no tags, so aliasing PCs share an entry.
    // ------------------------------------------------------------------------
    logic [IDX_BITS-1:0] w_if_idx;
    logic [IDX_BITS-1:0] w_ex_idx;

    assign w_if_idx = IF_PC[IDX_BITS+1:2];
    assign w_ex_idx = EX_PC[IDX_BITS+1:2];

    // Bits of EX_PC that do not take part in indexing.
    logic w_unused_ex_pc;
    assign w_unused_ex_pc = &{1'b0, EX_PC[1:0], EX_PC[DBITS-1:IDX_BITS+2]};

    // ------------------------------------------------------------------------
    // Fetch-side lookup (combinational, zero latency). The table is read
    // before any same-cycle write lands, so a lookup of the entry being
    // updated returns the old contents. Reset forces the fall-through path
    // directly so the outputs react without waiting for the storage.
    // ------------------------------------------------------------------------
    logic [1:0]       w_if_ctr;
    logic             w_if_valid;
    logic [DBITS-1:0] w_if_target;
    logic [DBITS-1:0] w_if_pc_plus4;
    logic             w_if_pred_taken;

    assign w_if_ctr        = r_ctr[w_if_idx];
    assign w_if_valid      = r_valid[w_if_idx];
    assign w_if_target     = r_target[w_if_idx];
    // Truncated to DBITS: wraps to zero past all-ones.
    assign w_if_pc_plus4   = IF_PC + DBITS'(4);
    assign w_if_pred_taken = ~reset & w_if_valid & w_if_ctr[1];

    assign IF_predTaken = w_if_pred_taken;
    assign IF_predPC    = w_if_pred_taken ? w_if_target : w_if_pc_plus4;

    // ------------------------------------------------------------------------
    // Execute-side update qualification
    // ------------------------------------------------------------------------
    logic w_update;
    logic w_mispred;

    assign w_update  = EX_valid && (EX_opcode == BRANCH_OP);
    assign w_mispred = (EX_pred != EX_taken);

    // ------------------------------------------------------------------------
    // Counter next-state for the entry addressed by EX_PC
    // ------------------------------------------------------------------------
    ctr_state_t w_ex_ctr_cur;
    ctr_state_t w_ex_ctr_nxt;

    assign w_ex_ctr_cur = r_ctr[w_ex_idx];

    always_comb begin
        w_ex_ctr_nxt = w_ex_ctr_cur;
        case (w_ex_ctr_cur)
            SNT:     w_ex_ctr_nxt = EX_taken ? WNT : SNT;
            WNT:     w_ex_ctr_nxt = EX_taken ? WT  : SNT;
            WT:      w_ex_ctr_nxt = EX_taken ? ST  : WNT;
            ST:      w_ex_ctr_nxt = EX_taken ? ST  : WT;
            default: w_ex_ctr_nxt = WNT;
        endcase
    end

    // ------------------------------------------------------------------------
    // Table write. A not-taken outcome only moves the counter: the target
    // of the last taken resolution is kept for when the entry turns taken
    // again.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_ctr[i]    <= WNT;
                r_valid[i]  <= 1'b0;
                r_target[i] <= '0;
            end
        end else if (w_update) begin
            r_ctr[w_ex_idx] <= w_ex_ctr_nxt;
            if (EX_taken) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_target[w_ex_idx] <= EX_target;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Statistics counters, both saturating at all-ones
    // ------------------------------------------------------------------------
    logic w_branch_sat;
    logic w_mispred_sat;

    assign w_branch_sat  = &r_branch_cnt;
    assign w_mispred_sat = &r_mispred_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_update) begin
            if (!w_branch_sat) begin
                r_branch_cnt <= r_branch_cnt + STAT_BITS'(1);
            end
            if (w_mispred && !w_mispred_sat) begin
                r_mispred_cnt <= r_mispred_cnt + STAT_BITS'(1);
            end
        end
    end

    assign branchCount  = r_branch_cnt;
    assign mispredCount = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Self-checking bench for branch_predictor. A table of
//                directed vectors is applied one per cycle; each vector's
//                expected outputs describe the table state before that
//                cycle's update edge. Reset and saturation corners are
//                exercised by hand-written sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam logic [3:0] c_BR  = 4'b0010;
    localparam logic [3:0] c_ALU = 4'b1100;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IF_PC;
    logic        IF_predTaken;
    logic [31:0] IF_predPC;
    logic        EX_valid;
    logic [31:0] EX_PC;
    logic [3:0]  EX_opcode;
    logic        EX_taken;
    logic [31:0] EX_target;
    logic        EX_pred;
    logic [15:0] branchCount;
    logic [15:0] mispredCount;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_predictor #(
        .DBITS     (32),
        .IDX_BITS  (4),
        .BRANCH_OP (4'b0010),
        .STAT_BITS (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .IF_PC        (IF_PC),
        .IF_predTaken (IF_predTaken),
        .IF_predPC    (IF_predPC),
        .EX_valid     (EX_valid),
        .EX_PC        (EX_PC),
        .EX_opcode    (EX_opcode),
        .EX_taken     (EX_taken),
        .EX_target    (EX_target),
        .EX_pred      (EX_pred),
        .branchCount  (branchCount),
        .mispredCount (mispredCount)
    );

    typedef struct {
        logic [31:0] if_pc;
        logic        ex_valid;
        logic [31:0] ex_pc;
        logic [3:0]  ex_op;
        logic        ex_taken;
        logic [31:0] ex_target;
        logic        ex_pred;
        logic        exp_taken;
        logic [31:0] exp_pc;
        logic [15:0] exp_bc;
        logic [15:0] exp_mc;
    } vec_t;

    localparam int c_NVEC = 17;
    vec_t vecs [c_NVEC];

    function automatic vec_t mk(
        input logic [31:0] if_pc,
        input logic        ex_valid,
        input logic [31:0] ex_pc,
        input logic [3:0]  ex_op,
        input logic        ex_taken,
        input logic [31:0] ex_target,
        input logic        ex_pred,
        input logic        exp_taken,
        input logic [31:0] exp_pc,
        input logic [15:0] exp_bc,
        input logic [15:0] exp_mc
    );
        vec_t v;
        v.if_pc     = if_pc;
        v.ex_valid  = ex_valid;
        v.ex_pc     = ex_pc;
        v.ex_op     = ex_op;
        v.ex_taken  = ex_taken;
        v.ex_target = ex_target;
        v.ex_pred   = ex_pred;
        v.exp_taken = exp_taken;
        v.exp_pc    = exp_pc;
        v.exp_bc    = exp_bc;
        v.exp_mc    = exp_mc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic exp_t, input logic [31:0] exp_pc,
                              input logic [15:0] exp_bc, input logic [15:0] exp_mc);
        check({tag, " predTaken"},    {31'd0, IF_predTaken}, {31'd0, exp_t});
        check({tag, " predPC"},       IF_predPC, exp_pc);
        check({tag, " branchCount"},  {16'd0, branchCount}, {16'd0, exp_bc});
        check({tag, " mispredCount"}, {16'd0, mispredCount}, {16'd0, exp_mc});
    endtask

    task automatic drive(input vec_t v);
        IF_PC     = v.if_pc;
        EX_valid  = v.ex_valid;
        EX_PC     = v.ex_pc;
        EX_opcode = v.ex_op;
        EX_taken  = v.ex_taken;
        EX_target = v.ex_target;
        EX_pred   = v.ex_pred;
    endtask

    task automatic idle(input logic [31:0] if_pc);
        IF_PC     = if_pc;
        EX_valid  = 1'b0;
        EX_PC     = '0;
        EX_opcode = '0;
        EX_taken  = 1'b0;
        EX_target = '0;
        EX_pred   = 1'b0;
    endtask

    initial begin
        // Expected outputs are the state BEFORE this vector's update edge.
        //            IF_PC         vld EX_PC        op     tk  tgt          pr  eT  ePC          bc  mc
        vecs[0]  = mk(32'h00000010, 0, 32'h0,        c_BR,  0, 32'h0,       0,  0, 32'h00000014, 0, 0);
        vecs[1]  = mk(32'h00000004, 1, 32'h04,       c_BR,  1, 32'h08,      0,  0, 32'h00000008, 0, 0); // WNT->WT
        vecs[2]  = mk(32'h00000004, 1, 32'h04,       c_BR,  1, 32'h08,      0,  1, 32'h00000008, 1, 1); // WT->ST
        vecs[3]  = mk(32'h00000004, 1, 32'h04,       c_BR,  0, 32'h99,      1,  1, 32'h00000008, 2, 2); // ST->WT
        vecs[4]  = mk(32'h00000004, 1, 32'h04,       c_BR,  0, 32'h99,      1,  1, 32'h00000008, 3, 3); // WT->WNT
        vecs[5]  = mk(32'h00000044, 1, 32'h04,       c_BR,  0, 32'h99,      1,  0, 32'h00000048, 4, 4); // WNT->SNT
        vecs[6]  = mk(32'h00000004, 1, 32'h04,       c_BR,  1, 32'h08,      0,  0, 32'h00000008, 5, 5); // SNT->WNT
        vecs[7]  = mk(32'h00000004, 0, 32'h04,       c_BR,  1, 32'h70,      0,  0, 32'h00000008, 6, 6); // bubble
        vecs[8]  = mk(32'h00000004, 1, 32'h04,       c_ALU, 1, 32'h70,      0,  0, 32'h00000008, 6, 6); // non-branch
        vecs[9]  = mk(32'h00000004, 0, 32'h0,        c_BR,  0, 32'h0,       0,  0, 32'h00000008, 6, 6);
        vecs[10] = mk(32'h00000004, 1, 32'h44,       c_BR,  1, 32'h44,      1,  0, 32'h00000008, 6, 6); // alias, same-cycle
        vecs[11] = mk(32'h00000004, 0, 32'h0,        c_BR,  0, 32'h0,       0,  1, 32'h00000044, 7, 6);
        vecs[12] = mk(32'h00000020, 1, 32'h20,       c_BR,  0, 32'h0,       0,  0, 32'h00000024, 7, 6); // correct NT
        vecs[13] = mk(32'hFFFFFFFC, 0, 32'h0,        c_BR,  0, 32'h0,       0,  0, 32'h00000000, 8, 6); // +4 wraps
        vecs[14] = mk(32'h00000020, 1, 32'hFFFFFFFC, c_BR,  1, 32'h100,     0,  0, 32'h00000024, 8, 6);
        vecs[15] = mk(32'hFFFFFFFC, 0, 32'h0,        c_BR,  0, 32'h0,       0,  1, 32'h00000100, 9, 7);
        vecs[16] = mk(32'h0000003C, 0, 32'h0,        c_BR,  0, 32'h0,       0,  1, 32'h00000100, 9, 7); // idx 15 alias

        // Reset
        reset = 1'b0;
        idle(32'h00000010);
        #1 reset = 1'b1;
        #2;
        check_outs("reset", 1'b0, 32'h00000014, 16'd0, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < c_NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_outs($sformatf("v%0d", i), vecs[i].exp_taken, vecs[i].exp_pc,
                       vecs[i].exp_bc, vecs[i].exp_mc);
        end

        // Mid-cycle asynchronous reset
        @(negedge clk);
        idle(32'h00000004);
        #1;
        check_outs("pre_rst", 1'b1, 32'h00000044, 16'd9, 16'd7);
        #2 reset = 1'b1;
        #1;
        check_outs("mid_rst", 1'b0, 32'h00000008, 16'd0, 16'd0);
        IF_PC = 32'hFFFFFFFC;
        #1;
        check("mid_rst wrap predPC", IF_predPC, 32'h00000000);
        @(negedge clk);
        reset = 1'b0;
        IF_PC = 32'h00000004;
        #1;
        check_outs("post_rst", 1'b0, 32'h00000008, 16'd0, 16'd0);

        // Counter must restart at WNT: one taken update makes it predict taken.
        @(negedge clk);
        drive(mk(32'h00000004, 1, 32'h04, c_BR, 1, 32'h08, 0, 0, 0, 0, 0));
        @(negedge clk);
        idle(32'h00000004);
        #1;
        check_outs("rst_wnt", 1'b1, 32'h00000008, 16'd1, 16'd1);

        // Statistics saturation: mispredicted branches every cycle.
        @(negedge clk);
        drive(mk(32'h00000010, 1, 32'h08, c_BR, 1, 32'h30, 0, 0, 0, 0, 0));
        repeat (65540) @(posedge clk);
        @(negedge clk);
        check("sat branchCount",  {16'd0, branchCount},  32'h0000FFFF);
        check("sat mispredCount", {16'd0, mispredCount}, 32'h0000FFFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold branchCount",  {16'd0, branchCount},  32'h0000FFFF);
        check("hold mispredCount", {16'd0, mispredCount}, 32'h0000FFFF);
        idle(32'h00000008);
        #1;
        check("sat entry predPC", IF_predPC, 32'h00000030);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
